// File: rtl/icache_line_adaptor.sv
// Turns a single-cycle icache line request into a BEATS-beat memory burst read,
// then returns the reassembled line. Optional perf counters: ICACHE_ADAPTOR_PERF_EN.
//
// state | meaning
// IDLE  | waiting for read_i; latches the line-aligned address
// REQ   | read_o high, waiting for beat 0
// BURST | read_o high, collecting beats 1..BEATS-1 (gaps allowed)
// DONE  | resp_o pulse, line_o valid; request not re-accepted here
module icache_line_adaptor #(
  parameter int LINE_W   = 256,
  parameter int BEAT_W   = 64,
  parameter int BEATS    = 4,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic [31:0]       address_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i
`ifdef ICACHE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]       fill_count_o,
  output logic [31:0]       stall_count_o
`endif
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [31:0]         addr_q, addr_d;

  // Byte-offset bits are dropped on purpose: memory always fetches whole lines.
  logic unused_offset_bits;
  assign unused_offset_bits = ^address_i[OFFSET_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    read_o  = 1'b0;
    resp_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        read_o = 1'b1;
        if (resp_i) begin
          line_d[BEAT_W-1:0] = burst_i;
          cnt_d              = CNT_W'(1);
          state_d            = BURST;
        end
      end
      BURST: begin
        read_o = 1'b1;
        if (resp_i) begin
          line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = burst_i;
          // Incrementing past the last beat wraps the counter back to zero.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign line_o    = line_q;
  assign address_o = addr_q;

`ifdef ICACHE_ADAPTOR_PERF_EN
  logic [31:0] fill_cnt_q, fill_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == DONE) && (fill_cnt_q != 32'hFFFF_FFFF)) begin
      fill_cnt_d = fill_cnt_q + 32'd1;
    end
    if (((state_q == REQ) || (state_q == BURST)) && !resp_i &&
        (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fill_count_o  = fill_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_icache_line_adaptor.sv
// Bench for icache_line_adaptor: a directed table for one fill, directed corner
// sequences, then randomized fills checked against a transaction-level model.
module tb_icache_line_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i;
  logic [31:0]  address_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic [63:0]  burst_i;
  logic         resp_i;
`ifdef ICACHE_ADAPTOR_PERF_EN
  logic [31:0]  fill_count_o;
  logic [31:0]  stall_count_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [255:0] last_line;
  int           exp_fills;
  int           exp_stalls;

  icache_line_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .read_i        (read_i),
    .address_i     (address_i),
    .line_o        (line_o),
    .resp_o        (resp_o),
    .address_o     (address_o),
    .read_o        (read_o),
    .burst_i       (burst_i),
`ifdef ICACHE_ADAPTOR_PERF_EN
    .fill_count_o  (fill_count_o),
    .stall_count_o (stall_count_o),
`endif
    .resp_i        (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic spurious);
    read_i    = 1'b0;
    resp_i    = spurious;
    burst_i   = {$urandom, $urandom};
    address_i = $urandom;
    chk("idle_read_o", read_o, 1'b0);
    chk("idle_resp_o", resp_o, 1'b0);
    chk("idle_line_hold", line_o, last_line);
    step();
  endtask

  // One complete fill. Beat gaps follow pat (LSB first) when pat_len>0,
  // otherwise each cycle carries a beat with probability 1/(max_gap+1).
  // read_i drops once drop_after beats have been delivered (never if <0).
  task automatic fill(input logic [31:0] addr, input logic [15:0] pat, input int pat_len,
                      input int drop_after, input int max_gap);
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    int           n;
    int           cyc;
    logic         v;
    exp_line = '0;
    exp_addr = {addr[31:5], 5'b0};
    n        = 0;
    cyc      = 0;

    read_i    = 1'b1;
    address_i = addr;
    resp_i    = 1'($urandom_range(0, 1));
    burst_i   = {$urandom, $urandom};
    chk("accept_read_o", read_o, 1'b0);
    chk("accept_resp_o", resp_o, 1'b0);
    chk("accept_line_hold", line_o, last_line);
    step();

    while (n < 4 && cyc < 64) begin
      if (pat_len > 0) v = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else             v = ($urandom_range(0, max_gap) == 0);
      address_i = $urandom;
      resp_i    = v;
      burst_i   = {$urandom, $urandom};
      chk("fill_read_o", read_o, 1'b1);
      chk("fill_resp_o", resp_o, 1'b0);
      chk("fill_address_o", address_o, exp_addr);
      if (v) begin
        exp_line[n*64 +: 64] = burst_i;
        n++;
        if (drop_after >= 0 && n >= drop_after) read_i = 1'b0;
      end else begin
        exp_stalls++;
      end
      cyc++;
      step();
    end
    if (n < 4) begin
      chk("fill_beat_budget", n, 4);
      return;
    end

    resp_i  = 1'($urandom_range(0, 1));
    burst_i = {$urandom, $urandom};
    chk("done_resp_o", resp_o, 1'b1);
    chk("done_read_o", read_o, 1'b0);
    chk("done_line_o", line_o, exp_line);
    chk("done_address_o", address_o, exp_addr);
`ifdef ICACHE_ADAPTOR_PERF_EN
    chk("done_stall_count", stall_count_o, exp_stalls);
    chk("done_fill_count", fill_count_o, exp_fills);
`endif
    exp_fills++;
    last_line = exp_line;
    step();
`ifdef ICACHE_ADAPTOR_PERF_EN
    chk("post_fill_count", fill_count_o, exp_fills);
`endif
  endtask

  typedef struct {
    logic         read_i;
    logic [31:0]  addr;
    logic         resp_i;
    logic [63:0]  beat;
    logic         exp_read;
    logic         exp_resp;
    logic [31:0]  exp_addr;
    logic         chk_line;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [255:0] full_line;
    logic [31:0]  s0;
    logic [31:0]  f0;
    int           d;
    full_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    vecs[0] = '{1'b1, 32'h0000_1234, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1, 256'h0};
    vecs[1] = '{1'b1, 32'h0000_1234, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0000_1220, 1'b0, 256'h0};
    vecs[2] = '{1'b1, 32'h0000_1234, 1'b1, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 32'h0000_1220, 1'b0, 256'h0};
    vecs[3] = '{1'b1, 32'h0000_1234, 1'b1, 64'h2222_2222_2222_2222, 1'b1, 1'b0, 32'h0000_1220, 1'b0, 256'h0};
    vecs[4] = '{1'b1, 32'h0000_1234, 1'b1, 64'h3333_3333_3333_3333, 1'b1, 1'b0, 32'h0000_1220, 1'b0, 256'h0};
    vecs[5] = '{1'b1, 32'h0000_1234, 1'b1, 64'h4444_4444_4444_4444, 1'b1, 1'b0, 32'h0000_1220, 1'b0, 256'h0};
    vecs[6] = '{1'b1, 32'h0000_1234, 1'b0, 64'h0, 1'b0, 1'b1, 32'h0000_1220, 1'b1, full_line};
    vecs[7] = '{1'b0, 32'h0000_1234, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0000_1220, 1'b1, full_line};

    rst = 1'b1; read_i = 1'b0; address_i = '0; burst_i = '0; resp_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_read_o", read_o, 1'b0);
    chk("reset_resp_o", resp_o, 1'b0);
    chk("reset_address_o", address_o, 32'h0);
    chk("reset_line_o", line_o, 256'h0);
`ifdef ICACHE_ADAPTOR_PERF_EN
    chk("reset_fill_count", fill_count_o, 32'h0);
    chk("reset_stall_count", stall_count_o, 32'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      read_i    = vecs[i].read_i;
      address_i = vecs[i].addr;
      resp_i    = vecs[i].resp_i;
      burst_i   = vecs[i].beat;
      chk($sformatf("vec%0d_read_o", i), read_o, vecs[i].exp_read);
      chk($sformatf("vec%0d_resp_o", i), resp_o, vecs[i].exp_resp);
      chk($sformatf("vec%0d_address_o", i), address_o, vecs[i].exp_addr);
      if (vecs[i].chk_line) chk($sformatf("vec%0d_line_o", i), line_o, vecs[i].exp_line);
      step();
    end
    last_line  = full_line;
    exp_fills  = 1;
    exp_stalls = 1;

    // Gapped burst: beats arrive with pattern 1,0,0,1,1,0,1.
`ifdef ICACHE_ADAPTOR_PERF_EN
    s0 = stall_count_o;
`endif
    fill(32'h0000_1234, 16'h0059, 7, -1, 0);
`ifdef ICACHE_ADAPTOR_PERF_EN
    chk("gapped_stall_delta", stall_count_o - s0, 32'd3);
`endif
    idle_cycle(1'b0);

    // Back-to-back fills with read_i still high during DONE.
`ifdef ICACHE_ADAPTOR_PERF_EN
    f0 = fill_count_o;
`endif
    fill(32'h0000_0040, 16'h0, 0, -1, 0);
    fill(32'h0000_0080, 16'h0, 0, -1, 0);
`ifdef ICACHE_ADAPTOR_PERF_EN
    chk("b2b_fill_delta", fill_count_o - f0, 32'd2);
`endif
    idle_cycle(1'b0);

    repeat (3) idle_cycle(1'b1);
    fill(32'h3000_0010, 16'h0, 0, 1, 1);
    idle_cycle(1'b1);

    // Reset asserted mid-burst, three beats into the fill.
    read_i = 1'b1; address_i = 32'h5555_5544; resp_i = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      step();
    end
    resp_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_read_o", read_o, 1'b0);
    chk("midrst_resp_o", resp_o, 1'b0);
    chk("midrst_line_o", line_o, 256'h0);
    chk("midrst_address_o", address_o, 32'h0);
`ifdef ICACHE_ADAPTOR_PERF_EN
    chk("midrst_fill_count", fill_count_o, 32'h0);
    chk("midrst_stall_count", stall_count_o, 32'h0);
`endif
    step();
    chk("midrst_hold_resp_o", resp_o, 1'b0);
    rst        = 1'b0;
    last_line  = '0;
    exp_fills  = 0;
    exp_stalls = 0;
    repeat (2) idle_cycle(1'b1);
    fill(32'h5555_5544, 16'h0, 0, -1, 2);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) idle_cycle(1'($urandom_range(0, 1)));
      d = $urandom_range(0, 4);
      fill($urandom, 16'h0, 0, (d == 0) ? -1 : d, $urandom_range(0, 3));
    end
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache_line_adaptor.md
Name: icache_line_adaptor

Overview:
- Sits directly downstream of the icache controller. Converts its single-cycle line request (pmem_read/pmem_resp, 256-bit line) into a 4-beat, 64-bit burst read on the physical memory bus.
- Read-only: it serves instruction-line fills.
- Reassembles the beats into one 256-bit line, then pulses the cache-side response for exactly one cycle.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory burst beat width in bits.
- BEATS, 4, beats per line; equals LINE_W/BEAT_W.
- OFFSET_W, 5, byte-offset bits cleared from the line address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- read_i  in  1  cache line-read request (icache pmem_read); level, held until resp_o.
- address_i  in  32  cache request byte address.
- line_o  out  LINE_W  assembled line (icache pmem_rdata).
- resp_o  out  1  one-cycle pulse; line_o valid (icache pmem_resp).
- address_o  out  32  line-aligned memory address.
- read_o  out  1  memory burst read request.
- burst_i  in  BEAT_W  memory read beat.
- resp_i  in  1  memory beat valid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, read_o=0, resp_o=0, address_o=0, line_o=0, beat counter=0.
  - Holds while rst high.
  - Reset mid-burst aborts immediately; no resp_o is produced.
- States: IDLE, REQ, BURST, DONE.
- IDLE:
  - read_i=1 latches address_o={address_i[31:OFFSET_W], OFFSET_W'b0}; counter=0; next REQ.
  - read_i=0 stays IDLE.
- REQ:
  - read_o=1.
  - On resp_i=1: capture burst_i into line_o[63:0], counter=1, next BURST.
  - On resp_i=0: remain in REQ.
- BURST:
  - read_o=1.
  - Each cycle with resp_i=1 writes burst_i into line_o[counter*64 +: 64] and increments the counter.
  - Cycles with resp_i=0 (memory gap) hold the counter and line; they are not errors.
  - When the beat with counter==BEATS-1 is captured, next DONE.
- DONE:
  - resp_o=1 and read_o=0 for exactly one cycle; next IDLE.
  - The request is not re-accepted in DONE even though read_i is still high.
- Beat order and placement: beat k maps to line_o bits [64k+63:64k]. Beat 0 is the lowest address.
- Latency: resp_o rises one cycle after the 4th resp_i beat. Minimum request-to-response is 6 cycles (IDLE→REQ, 4 beats, DONE).
- line_o:
  - Partially updated during the burst; the cache must sample it only while resp_o=1.
  - Holds its last value after DONE until the next fill's first beat.
- address_o is stable from REQ through DONE; changes to address_i mid-fill are ignored.
- read_i dropping mid-fill: the burst still completes (memory cannot abort) and resp_o still pulses once; the cache ignores it.
- resp_i while IDLE or DONE: ignored, no line update.
- Counter is 2 bits and wraps 3→0 only on the DONE transition; no extra beats are accepted.
- Back-to-back misses: a new fill may start in the first IDLE cycle after DONE.

Optional Feature:
- Macro: ICACHE_ADAPTOR_PERF_EN.
- Defined:
  - Adds output ports fill_count_o [31:0] and stall_count_o [31:0]. Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - fill_count_o increments on each DONE.
  - stall_count_o increments every cycle spent in REQ or BURST with resp_i=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single fill:
  - Stimulus: read_i=1, address_i=32'h0000_1234; memory answers 2 cycles later with 4 consecutive beats 64'h1111…, 64'h2222…, 64'h3333…, 64'h4444….
  - Required: address_o=32'h0000_1220; resp_o pulses once; line_o={4444…,3333…,2222…,1111…}; read_o low in the DONE cycle.
- Gapped burst:
  - Stimulus: same request; resp_i pattern 1,0,0,1,1,0,1.
  - Required: beats placed in order 0..3; resp_o one cycle after the last beat; stall_count_o=3 with PERF_EN.
- Reset mid-burst:
  - Stimulus: assert rst after beat 2.
  - Required: read_o=0, line_o=0, state IDLE in the same cycle (async); no resp_o; a subsequent fill completes correctly.
- Back-to-back fills:
  - Stimulus: two misses to 32'h0000_0040 and 32'h0000_0080.
  - Required: two separate 4-beat bursts; two resp_o pulses; fill_count_o=2; no duplicate request from read_i held high in DONE.
- Spurious and abort cases:
  - Stimulus: resp_i=1 while IDLE; separately, drop read_i after beat 1.
  - Required: no line_o change in IDLE; the aborted fill still consumes 4 beats and pulses resp_o once.
